// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: shared FSM state encoding and default NORM timeout for the FP add sequencer
package fpu_ctrl_pkg;
  localparam int NORM_MAX_DEF = 56;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr
//   req         : request vector
//   ptr         : highest-priority index this round
//   grant_valid : any request present
//   grant_idx   : granted index
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_idx
);
  always_comb begin
    grant_valid = 1'b0;
    grant_idx = '0;
    // Walk from farthest to nearest so the nearest requester to ptr wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx = IW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: arbitrates requesters onto one FP adder datapath and sequences its stages
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/req_sub/req_ready: per-requester request, subtract flag, one-hot accept
//   op_sel, ld_operands        : operand mux select and load strobe
//   en_align..en_round, dp_sub : datapath stage enables and registered subtract flag
//   dp_special, norm_done      : special-value bypass and normalizer finished
//   rsp_valid/rsp_id/rsp_ready : result handshake and owner
//   busy, err, done_count      : not idle, sticky NORM timeout, completed operations
module fp_add_sequencer
  import fpu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NORM_MAX = NORM_MAX_DEF,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(NORM_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_sub,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [IW-1:0]      op_sel,
  output logic               ld_operands,
  output logic               en_align,
  output logic               en_add,
  output logic               en_norm,
  output logic               en_round,
  output logic               dp_sub,
  input  logic               dp_special,
  input  logic               norm_done,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  input  logic               rsp_ready,
  output logic               busy,
  output logic               err,
  output logic [15:0]        done_count
);
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, grant_idx;
  logic [CW-1:0] norm_cnt;
  logic grant_valid, grant, norm_to;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx)
  );

  always_comb begin
    // Gate with rst_n so no accept is ever signalled while reset is held.
    grant = rst_n && state == IDLE && grant_valid;
    norm_to = norm_cnt == CW'(NORM_MAX - 1);
    req_ready = grant ? NUM_REQ'(1) << grant_idx : '0;
    ld_operands = grant;
    op_sel = state == IDLE ? grant_idx : rsp_id;
    en_align = state == ALIGN;
    en_add = state == ADD;
    en_norm = state == NORM;
    en_round = state == ROUND;
    rsp_valid = state == DONE;
    busy = state != IDLE;
    state_nx = state;
    case (state)
      IDLE:  state_nx = grant ? ALIGN : IDLE;
      ALIGN: state_nx = dp_special ? DONE : ADD;
      ADD:   state_nx = NORM;
      NORM:  state_nx = norm_done || norm_to ? ROUND : NORM;
      ROUND: state_nx = DONE;
      DONE:  state_nx = rsp_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      err <= 1'b0;
      done_count <= '0;
      norm_cnt <= '0;
      dp_sub <= 1'b0;
      rsp_id <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        dp_sub <= req_sub[grant_idx];
        rsp_id <= grant_idx;
        rr_ptr <= IW'((int'(grant_idx) + 1) % NUM_REQ);
      end
      norm_cnt <= state == NORM && state_nx == NORM ? norm_cnt + 1'b1 : '0;
      if (state == NORM && !norm_done && norm_to) err <= 1'b1;
      if (state == DONE && rsp_ready) done_count <= done_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed self-checking bench for fp_add_sequencer
module tb_fp_add_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_sub, req_ready;
  logic op_sel, ld_operands, en_align, en_add, en_norm, en_round, dp_sub;
  logic dp_special, norm_done, rsp_valid, rsp_id, rsp_ready, busy, err;
  logic [15:0] done_count;
  int n_tests = 0;
  int n_fail = 0;

  fp_add_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sub(req_sub), .req_ready(req_ready),
    .op_sel(op_sel), .ld_operands(ld_operands), .en_align(en_align), .en_add(en_add),
    .en_norm(en_norm), .en_round(en_round), .dp_sub(dp_sub), .dp_special(dp_special),
    .norm_done(norm_done), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .busy(busy), .err(err), .done_count(done_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_op(input logic [1:0] rv, input logic [1:0] rs, input bit keep, input int id,
                       input int lat, input int nn, input int hold, input logic [15:0] dc);
    int t, n_add, n_norm, n_round, bad;
    t = 0; n_add = 0; n_norm = 0; n_round = 0; bad = 0;
    req_valid = rv;
    req_sub = rs;
    #1;
    check("grant_ready", 32'(req_ready), 32'(1 << id));
    check("grant_ld", 32'(ld_operands), 1);
    check("grant_sel", 32'(op_sel), id);
    @(negedge clk);
    t = 1;
    if (!keep) req_valid = '0;
    while (!rsp_valid && t < 200) begin
      n_add += int'(en_add);
      n_norm += int'(en_norm);
      n_round += int'(en_round);
      bad += int'($countones({ld_operands, en_align, en_add, en_norm, en_round}) > 1);
      bad += int'(req_ready != 2'b00);
      @(negedge clk);
      t++;
    end
    check("latency", t, lat);
    check("rsp_id", 32'(rsp_id), id);
    check("dp_sub", 32'(dp_sub), 32'(rs[id]));
    check("n_add", n_add, nn > 0 ? 1 : 0);
    check("n_norm", n_norm, nn);
    check("n_round", n_round, nn > 0 ? 1 : 0);
    repeat (hold) begin
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_id", 32'(rsp_id), id);
      check("hold_nogrant", 32'(req_ready), 0);
      check("hold_count", 32'(done_count), 32'(16'(dc - 16'd1)));
      @(negedge clk);
    end
    bad += int'({en_align, en_add, en_norm, en_round, ld_operands} != 5'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_count", 32'(done_count), 32'(dc));
    check("idle_busy", 32'(busy), 0);
    check("idle_rsp", 32'(rsp_valid), 0);
    check("exclusive", bad, 0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    req_valid = '0;
    req_sub = '0;
    dp_special = 1'b0;
    norm_done = 1'b1;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 2'b01;
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_ld", 32'(ld_operands), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp", 32'(rsp_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_count", 32'(done_count), 0);
    check("rst_en", 32'({en_align, en_add, en_norm, en_round}), 0);
    do_reset();

    do_op(2'b01, 2'b01, 1'b0, 0, 5, 1, 0, 16'd1);

    do_reset();
    do_op(2'b11, 2'b10, 1'b1, 0, 5, 1, 0, 16'd1);
    do_op(2'b11, 2'b10, 1'b1, 1, 5, 1, 4, 16'd2);
    do_op(2'b11, 2'b10, 1'b1, 0, 5, 1, 0, 16'd3);
    req_valid = '0;

    dp_special = 1'b1;
    do_op(2'b10, 2'b00, 1'b0, 1, 2, 0, 0, 16'd4);
    dp_special = 1'b0;
    check("err_before_to", 32'(err), 0);

    norm_done = 1'b0;
    do_op(2'b01, 2'b00, 1'b0, 0, 60, 56, 0, 16'd5);
    check("err_after_to", 32'(err), 1);

    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    check("mid_norm", 32'(en_norm), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_norm_busy", 32'(busy), 0);
    check("rst_norm_en", 32'(en_norm), 0);
    check("rst_norm_err", 32'(err), 0);
    check("rst_norm_count", 32'(done_count), 0);
    seen = int'(rsp_valid);
    repeat (5) begin
      @(negedge clk);
      seen += int'(rsp_valid);
    end
    check("rst_norm_rsp", seen, 0);

    norm_done = 1'b1;
    force dut.done_count = 16'hFFFF;
    @(negedge clk);
    release dut.done_count;
    @(negedge clk);
    check("preload", 32'(done_count), 32'h0000FFFF);
    do_op(2'b01, 2'b00, 1'b0, 0, 5, 1, 0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
